// File: rtl/bitonic_unloader_if.sv
// bitonic_unloader_if: sorted-vector capture handshake plus element output stream.
// master is the unloader's view, slave is the sorter/consumer side.
interface bitonic_unloader_if #(
    parameter int NUM_INPUT  = 16,
    parameter int DATA_WIDTH = 8
);
    localparam int IW = $clog2(NUM_INPUT);
    logic [NUM_INPUT*DATA_WIDTH-1:0] sorted_in;
    logic                            sorted_valid;
    logic                            in_ready;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_valid;
    logic                            out_ready;
    logic                            out_last;
    logic [IW-1:0]                   out_index;
    logic                            overflow;
    modport master (
        input  sorted_in, sorted_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, out_index, overflow
    );
    modport slave (
        output sorted_in, sorted_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_index, overflow
    );
endinterface

// File: rtl/bitonic_unloader.sv
// bitonic_unloader: captures one sorted vector and streams it out lane 0 first.
// Define BITONIC_UNLOADER_SKID_EN to add a shadow vector for bubble-free back-to-back drains.
module bitonic_unloader #(
    parameter int NUM_INPUT  = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    bitonic_unloader_if.master  bus
);
    localparam int IW = $clog2(NUM_INPUT);
    localparam int W  = NUM_INPUT * DATA_WIDTH;
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state, state_nxt;
    logic [W-1:0]  act_buf;
    logic [IW-1:0] idx;
    logic          ovf;
    logic          take, hs, last_hs;
    logic [W-1:0]  shadow;
    logic          shadow_full;
    assign take    = bus.sorted_valid && bus.in_ready;
    assign hs      = bus.out_valid && bus.out_ready;
    assign last_hs = hs && bus.out_last;
`ifdef BITONIC_UNLOADER_SKID_EN
    assign bus.in_ready = !shadow_full;
    // The shadow fills only mid-drain; a vector accepted on the last handshake loads act_buf directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow      <= '0;
            shadow_full <= 1'b0;
        end else if (state == DRAIN && last_hs && shadow_full) begin
            shadow_full <= 1'b0;
        end else if (state == DRAIN && take && !last_hs) begin
            shadow      <= bus.sorted_in;
            shadow_full <= 1'b1;
        end
    end
`else
    assign bus.in_ready = state == IDLE;
    assign shadow       = '0;
    assign shadow_full  = 1'b0;
`endif
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = take ? DRAIN : IDLE;
        else if (last_hs && !shadow_full && !take)
            state_nxt = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            act_buf <= '0;
            idx     <= '0;
            ovf     <= 1'b0;
        end else begin
            if (bus.sorted_valid && !bus.in_ready)
                ovf <= 1'b1;
            if (state == IDLE) begin
                if (take) begin
                    act_buf <= bus.sorted_in;
                    idx     <= '0;
                end
            end else if (last_hs) begin
                act_buf <= shadow_full ? shadow : bus.sorted_in;
                idx     <= '0;
            end else if (hs) begin
                idx <= idx + IW'(1);
            end
        end
    end
    assign bus.out_valid = state == DRAIN;
    assign bus.out_data  = bus.out_valid ? act_buf[DATA_WIDTH*idx +: DATA_WIDTH] : '0;
    assign bus.out_index = idx;
    assign bus.out_last  = bus.out_valid && (idx == IW'(NUM_INPUT - 1));
    assign bus.overflow  = ovf;
endmodule

// File: tb/tb_bitonic_unloader.sv
// tb_bitonic_unloader: directed and random stimulus checked every cycle against
// a queue-of-vectors model of the unloader.
module tb_bitonic_unloader;
    localparam int N  = 4;
    localparam int DW = 8;
`ifdef BITONIC_UNLOADER_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    bitonic_unloader_if #(.NUM_INPUT(N), .DATA_WIDTH(DW)) bus ();
    bitonic_unloader #(.NUM_INPUT(N), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    logic [N*DW-1:0] q[$];
    int              pos = 0;
    logic            m_ovf = 1'b0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Called at a falling edge: compare outputs, then drive inputs for the next rising edge.
    task automatic step(input logic rs, input logic sv, input logic [N*DW-1:0] v, input logic ordy);
        logic       ov;
        logic [7:0] d;
        logic       acc;
        ov = q.size() > 0;
        d  = '0;
        if (ov) d = q[0][DW*pos +: DW];
        check("in_ready", 32'(bus.in_ready), 32'(q.size() < CAP));
        check("out_valid", 32'(bus.out_valid), 32'(ov));
        check("out_data", 32'(bus.out_data), 32'(d));
        check("out_index", 32'(bus.out_index), ov ? pos : 0);
        check("out_last", 32'(bus.out_last), 32'(ov && pos == N - 1));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        reset            = rs;
        bus.sorted_valid = sv;
        bus.sorted_in    = v;
        bus.out_ready    = ordy;
        if (rs) begin
            q.delete();
            pos   = 0;
            m_ovf = 1'b0;
        end else begin
            acc = sv && q.size() < CAP;
            if (sv && !acc) m_ovf = 1'b1;
            if (ov && ordy) begin
                if (pos == N - 1) begin
                    void'(q.pop_front());
                    pos = 0;
                end else pos++;
            end
            if (acc) q.push_back(v);
        end
        @(negedge clk);
    endtask
    initial begin
        reset = 1'b1;
        bus.sorted_valid = 1'b0;
        bus.sorted_in = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // basic drain
        step(0, 1, 32'h1F0A0703, 1);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1);
        // backpressure on cycles 2-4 after capture
        step(0, 1, 32'h1F0A0703, 1);
        for (int i = 1; i <= 8; i++) step(0, 0, '0, !(i >= 2 && i <= 4));
        // second vector offered mid-drain, then reset clears overflow
        step(0, 1, 32'hA1B2C3D4, 1);
        step(0, 0, '0, 1);
        step(0, 1, 32'h55667788, 1);
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1);
        step(1, 0, '0, 1);
        step(0, 0, '0, 1);
        // back-to-back vectors two cycles apart
        step(0, 1, 32'h04030201, 1);
        step(0, 0, '0, 1);
        step(0, 1, 32'h08070605, 1);
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1);
        // reset mid-drain, then a fresh vector
        step(0, 1, 32'h44332211, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(1, 0, '0, 1);
        step(0, 1, 32'hDDCCBBAA, 1);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1);
        // random traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(99) == 0, $urandom_range(3) == 0, N*DW'($urandom()), $urandom_range(3) != 0);
        step(0, 0, '0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
